// File: rtl/step_size_estimator.sv
// Estimates the phase-accumulator step size of a sample stream from the period between
// rising zero crossings (with hysteresis), using a bit-serial restoring divider.
module step_size_estimator #(
    parameter int ADDRESS_SIZE = 8,
    parameter int DATA_SIZE    = 8,
    parameter int PRECISION    = 16,
    parameter int PERIOD_WIDTH = 32,
    parameter int HYSTERESIS   = 0
) (
    input  logic                                        i_clk,
    input  logic                                        i_res,
    input  logic                                        i_valid,
    input  logic signed [DATA_SIZE+PRECISION-1:0]       i_data,
    output logic        [ADDRESS_SIZE+PRECISION-1:0]    o_step_size,
    output logic                                        o_valid,
    output logic                                        o_busy,
    output logic                                        o_overrun
);

    localparam int SW = ADDRESS_SIZE + PRECISION;
    localparam int DW = DATA_SIZE + PRECISION;
    localparam int PW = PERIOD_WIDTH;
    localparam int QW = SW + 1;
    localparam int BW = $clog2(QW + 1);
    localparam logic signed [DW-1:0] ARM_LEVEL = DW'(-HYSTERESIS);
    localparam logic        [PW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t          state;
    logic            armed;
    logic            started;
    logic [PW-1:0]   count;
    logic [PW-1:0]   period;
    logic [PW:0]     rem;
    logic [QW-1:0]   quo;
    logic [BW-1:0]   bit_idx;

    logic            crossing;
    logic            arm_hit;
    logic            dividend_bit;
    logic [PW:0]     rem_shift;
    logic            rem_ge;

    always_comb begin
        crossing     = i_valid && armed && !i_data[DW-1];
        arm_hit      = i_valid && (i_data < ARM_LEVEL);
        // The dividend 2^SW has a single set bit, so it is generated from the bit index.
        dividend_bit = (bit_idx == BW'(SW));
        rem_shift    = (rem << 1) | (PW+1)'(dividend_bit);
        rem_ge       = (rem_shift >= {1'b0, period});
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state       <= IDLE;
            armed       <= 1'b0;
            started     <= 1'b0;
            count       <= '0;
            period      <= '0;
            rem         <= '0;
            quo         <= '0;
            bit_idx     <= '0;
            o_step_size <= '0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;

            if (crossing) begin
                armed   <= 1'b0;
                started <= 1'b1;
                count   <= PW'(1);
                if (started) begin
                    if (state != IDLE) begin
                        o_overrun <= 1'b1;
                    end else begin
                        period  <= count;
                        rem     <= '0;
                        quo     <= '0;
                        bit_idx <= BW'(SW);
                        // A saturated period yields a zero estimate without dividing.
                        if (count == CNT_MAX) begin
                            state <= DONE;
                        end else begin
                            state  <= DIV;
                            o_busy <= 1'b1;
                        end
                    end
                end
            end else if (i_valid) begin
                if (arm_hit) begin
                    armed <= 1'b1;
                end
                if (count != CNT_MAX) begin
                    count <= count + PW'(1);
                end
            end

            case (state)
                DIV: begin
                    rem <= rem_ge ? (rem_shift - {1'b0, period}) : rem_shift;
                    quo <= (quo << 1) | QW'(rem_ge);
                    if (bit_idx == '0) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx - BW'(1);
                    end
                end
                DONE: begin
                    o_step_size <= quo[SW-1:0];
                    o_valid     <= 1'b1;
                    state       <= IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_step_size_estimator.sv
// Bench for step_size_estimator: three configurations share one stimulus stream and are
// checked every cycle against an event-time reference model, plus table and corner sequences.
module tb_step_size_estimator;

    localparam int SW   = 24;
    localparam int DW   = 24;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 res;
    logic                 valid;
    logic signed [DW-1:0] data;
    logic [SW-1:0]        st   [NDUT];
    logic                 ov   [NDUT];
    logic                 bz   [NDUT];
    logic                 orun [NDUT];

    step_size_estimator dut0 (
        .i_clk(clk), .i_res(res), .i_valid(valid), .i_data(data),
        .o_step_size(st[0]), .o_valid(ov[0]), .o_busy(bz[0]), .o_overrun(orun[0]));
    step_size_estimator #(.HYSTERESIS(100)) dut1 (
        .i_clk(clk), .i_res(res), .i_valid(valid), .i_data(data),
        .o_step_size(st[1]), .o_valid(ov[1]), .o_busy(bz[1]), .o_overrun(orun[1]));
    step_size_estimator #(.PERIOD_WIDTH(4)) dut2 (
        .i_clk(clk), .i_res(res), .i_valid(valid), .i_data(data),
        .o_step_size(st[2]), .o_valid(ov[2]), .o_busy(bz[2]), .o_overrun(orun[2]));

    int     n_cmp = 0;
    int     n_bad = 0;
    longint t     = 0;

    int     hyst [NDUT];
    longint sat  [NDUT];

    // Model: crossings from the sample rules; a result is due 26 edges after acceptance.
    bit     m_armed [NDUT];
    bit     m_started [NDUT];
    longint m_cnt [NDUT];
    longint m_done [NDUT];
    longint m_busy_hi [NDUT];
    longint m_pend [NDUT];
    longint m_step [NDUT];
    bit     e_valid [NDUT];
    bit     e_busy [NDUT];
    bit     e_ovr [NDUT];

    bit     cap_seen [NDUT];
    longint cap_val [NDUT];
    longint cap_t [NDUT];
    int     n_valid [NDUT];
    int     n_ovr [NDUT];

    typedef struct {
        int     neg_len;
        int     neg_val;
        int     pos_len;
        int     pos_val;
        bit     gap;
        int     periods;
        longint exp_val [NDUT];
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", name, k, t, act, exp);
        end
    endtask

    task automatic model_edge(input int k, input bit v, input int d, input bit r);
        if (r) begin
            m_armed[k] = 0; m_started[k] = 0; m_cnt[k] = 0;
            m_done[k] = -1; m_busy_hi[k] = -1; m_step[k] = 0;
            e_valid[k] = 0; e_busy[k] = 0; e_ovr[k] = 0;
        end else begin
            e_valid[k] = (m_done[k] == t);
            if (e_valid[k]) m_step[k] = m_pend[k];
            e_busy[k] = (t <= m_busy_hi[k]);
            e_ovr[k]  = 0;
            if (v) begin
                if (m_armed[k] && d >= 0) begin
                    if (m_started[k]) begin
                        if (t <= m_done[k]) begin
                            e_ovr[k] = 1;
                        end else if (m_cnt[k] == sat[k]) begin
                            m_pend[k] = 0;
                            m_done[k] = t + 1;
                        end else begin
                            m_pend[k]    = (longint'(1) << 24) / m_cnt[k];
                            m_done[k]    = t + 26;
                            m_busy_hi[k] = t + 24;
                            e_busy[k]    = 1;
                        end
                    end
                    m_started[k] = 1;
                    m_cnt[k]     = 1;
                    m_armed[k]   = 0;
                end else begin
                    if (d < -hyst[k]) m_armed[k] = 1;
                    if (m_cnt[k] < sat[k]) m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input int d, input bit r);
        valid = v;
        data  = DW'(d);
        res   = r;
        @(posedge clk);
        t++;
        for (int k = 0; k < NDUT; k++) model_edge(k, v, d, r);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("o_valid",     k, longint'(ov[k]),   longint'(e_valid[k]));
            chk("o_busy",      k, longint'(bz[k]),   longint'(e_busy[k]));
            chk("o_overrun",   k, longint'(orun[k]), longint'(e_ovr[k]));
            chk("o_step_size", k, longint'(st[k]),   m_step[k]);
            if (ov[k] === 1'b1) begin
                n_valid[k]++;
                if (!cap_seen[k]) begin
                    cap_seen[k] = 1;
                    cap_val[k]  = longint'(st[k]);
                    cap_t[k]    = t;
                end
            end
            if (orun[k] === 1'b1) n_ovr[k]++;
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < NDUT; k++) begin
            cap_seen[k] = 0; cap_val[k] = -1; cap_t[k] = -1;
            n_valid[k] = 0; n_ovr[k] = 0;
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 0, 1'b1);
        clear_stats();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, -500, 1'b0);
    endtask

    task automatic square(input int nl, input int nv, input int pl, input int pv,
                          input bit gap, input int periods);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < nl + pl; i++) begin
                if (gap) cyc(1'b0, -500, 1'b0);
                cyc(1'b1, (i < nl) ? nv : pv, 1'b0);
            end
        end
    endtask

    task automatic gen(input int step, input int cycles);
        logic [23:0] ph;
        ph = '0;
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b1, ph[23] ? -1000 : 1000, 1'b0);
            ph = ph + 24'(step);
        end
    endtask

    initial begin
        longint t0;
        res = 1'b1; valid = 1'b0; data = '0;
        hyst = '{0, 100, 0};
        sat  = '{(longint'(1) << 32) - 1, (longint'(1) << 32) - 1, 15};
        clear_stats();

        vecs[0] = '{5,   -5,    5,  5,    1'b0, 3, '{1677721, -1, 1677721}};
        vecs[1] = '{1,   -1,    2,  0,    1'b0, 4, '{5592405, -1, 5592405}};
        vecs[2] = '{1,   -1,    2,  0,    1'b1, 4, '{5592405, -1, 5592405}};
        vecs[3] = '{10,  -200,  10, 200,  1'b0, 3, '{838860, 838860, 0}};
        vecs[4] = '{128, -1000, 128, 1000, 1'b0, 3, '{65536, 65536, 0}};
        vecs[5] = '{2,   -5,    20, 5,    1'b0, 3, '{762600, -1, 0}};

        do_reset();
        for (int k = 0; k < NDUT; k++) chk("reset_step", k, longint'(st[k]), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            square(vecs[v].neg_len, vecs[v].neg_val, vecs[v].pos_len, vecs[v].pos_val,
                   vecs[v].gap, vecs[v].periods);
            idle(40);
            for (int k = 0; k < NDUT; k++)
                chk("table_first_estimate", k, cap_seen[k] ? cap_val[k] : -1, vecs[v].exp_val[k]);
        end

        // Latency of a normal division and of a saturated period.
        do_reset();
        t0 = t;
        square(5, -5, 5, 5, 1'b0, 3);
        idle(40);
        chk("latency_n10", 0, cap_t[0] - (t0 + 16), 26);
        do_reset();
        t0 = t;
        square(2, -5, 20, 5, 1'b0, 2);
        idle(5);
        chk("latency_saturated", 2, cap_t[2] - (t0 + 25), 1);

        // Crossings every 10 samples land inside the running division.
        do_reset();
        square(5, -5, 5, 5, 1'b0, 4);
        idle(40);
        chk("overrun_count", 0, n_ovr[0], 2);
        chk("overrun_valid_count", 0, n_valid[0], 1);
        chk("overrun_result", 0, cap_val[0], 1677721);

        // Reset mid-division aborts; two fresh crossings are needed afterwards.
        do_reset();
        square(5, -5, 5, 5, 1'b0, 1);
        square(5, -5, 1, 5, 1'b0, 1);
        for (int i = 0; i < 5; i++) cyc(1'b1, (i < 4) ? 5 : -5, 1'b0);
        cyc(1'b0, 0, 1'b1);
        chk("abort_busy", 0, longint'(bz[0]), 0);
        chk("abort_step", 0, longint'(st[0]), 0);
        clear_stats();
        idle(40);
        chk("abort_no_valid", 0, n_valid[0], 0);
        square(5, -5, 5, 5, 1'b0, 1);
        idle(35);
        chk("abort_one_crossing", 0, n_valid[0], 0);
        square(5, -5, 5, 5, 1'b0, 1);
        idle(30);
        chk("abort_two_crossings", 0, n_valid[0], 1);

        // Hysteresis: small noise never arms the thresholded detector.
        do_reset();
        for (int i = 0; i < 30; i++) cyc(1'b1, int'($urandom_range(0, 100)) - 50, 1'b0);
        square(10, -200, 10, 200, 1'b0, 1);
        for (int i = 0; i < 10; i++) cyc(1'b1, -200, 1'b0);
        cyc(1'b1, 200, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, int'($urandom_range(0, 100)) - 50, 1'b0);
        chk("hysteresis_estimate", 1, cap_val[1], 838860);
        chk("hysteresis_count", 1, n_valid[1], 1);

        // Generator-driven input.
        do_reset();
        gen(65536, 800);
        chk("gen_256", 0, cap_val[0], 65536);
        do_reset();
        gen(3 * 65536, 600);
        chk("gen_85_first", 0,
            longint'(cap_val[0] == 197379 || cap_val[0] == 195083), 1);
        chk("gen_85_seen", 0, longint'(n_valid[0] > 3), 1);

        // Randomised segments with gaps, noise and occasional resets.
        do_reset();
        repeat (120) begin
            int len, amp, sgn;
            len = $urandom_range(1, 30);
            amp = $urandom_range(0, 300);
            sgn = ($urandom % 2) ? 1 : -1;
            for (int i = 0; i < len; i++)
                cyc(($urandom % 4) != 0, sgn * amp + int'($urandom_range(0, 40)) - 20,
                    ($urandom % 1500) == 0);
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
